vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter_pkg.sv | 22 ++
 rtl/vga_fb_arbiter_line_buffer.sv | 37 +++
 rtl/vga_fb_arbiter.sv | 159 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Package  : vga_fb_arbiter_pkg
// Brief    : Shared VGA types and framebuffer geometry defaults.
// Revision : 1.0
//==============================================================================
package vga_fb_arbiter_pkg;

  typedef logic [11:0] color_t;

  localparam int VGA_SCALE = 4;
  localparam int VGA_FB_W  = 200;
  localparam int VGA_FB_H  = 150;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_fb_arbiter_line_buffer.sv
`default_nettype none
//==============================================================================
// Module   : vga_fb_arbiter_line_buffer
// Brief    : Two-bank line buffer, one write port, one registered read port.
// Revision : 1.0
//==============================================================================
module vga_fb_arbiter_line_buffer
  import vga_fb_arbiter_pkg::*;
#(
  parameter int DEPTH = VGA_FB_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic          i_wr_bank,
  input  logic [AW-1:0] i_wr_addr,
  input  color_t        i_wr_data,
  input  logic          i_rd_bank,
  input  logic [AW-1:0] i_rd_addr,
  output color_t        o_rd_data
);

  // Storage is deliberately not reset; validity is tracked by the arbiter.
  color_t r_mem [0:1][0:DEPTH-1];
  color_t r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : vga_fb_arbiter
// Brief    : Shares a single-port framebuffer between line prefetch and a writer.
// Revision : 1.0
//==============================================================================
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int WIDTH   = 800,
  parameter int HEIGHT  = 600,
  parameter int V_TOTAL = 666,
  parameter int SCALE   = VGA_SCALE,
  parameter int FB_W    = VGA_FB_W,
  parameter int FB_H    = VGA_FB_H
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic [15:0] pix_x,
  input  logic [15:0] pix_y,
  output color_t      col,
  output logic [14:0] fb_addr,
  output logic        fb_rd_en,
  output logic        fb_wr_en,
  output color_t      fb_wdata,
  input  color_t      fb_rdata,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [7:0]  wr_y,
  input  color_t      wr_color
);

  localparam int CW = $clog2(FB_W);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [14:0]      r_row_base;
  logic             r_bank;
  logic [1:0]       r_valid;
  logic             r_lbw_en;
  logic [CW-1:0]    r_lbw_col;
  logic             r_blank;

  logic [31:0]      w_px;
  logic [31:0]      w_py;
  logic [31:0]      w_nx;
  logic [31:0]      w_ny;
  logic [31:0]      w_row_next;
  logic             w_trig;
  logic             w_rd_bank;
  logic             w_rd_ok;
  logic [CW-1:0]    w_lb_raddr;
  color_t           w_lb_rdata;
  logic             w_xfer;
  logic             w_wr_in;

  assign w_px = 32'(pix_x);
  assign w_py = 32'(pix_y);
  assign w_nx = w_px + 32'd1;
  assign w_ny = w_py + 32'd1;

  // Fetch the row that becomes visible on the next line; frame end reloads row 0.
  assign w_trig     = (w_px == WIDTH) &&
                      ((((w_ny % SCALE) == 32'd0) && (w_ny < HEIGHT)) || (w_py == V_TOTAL - 1));
  assign w_row_next = (w_py == V_TOTAL - 1) ? 32'd0 : (w_ny / SCALE);

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_trig) w_state_nxt = FETCH;
      FETCH:   if (r_cnt == CW'(FB_W - 1)) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_row_base <= '0;
      r_bank     <= 1'b0;
      r_valid    <= 2'b00;
      r_lbw_en   <= 1'b0;
      r_lbw_col  <= '0;
      r_blank    <= 1'b1;
    end else begin
      r_lbw_en  <= (r_state == FETCH);
      r_lbw_col <= r_cnt;
      r_blank   <= !w_rd_ok;
      case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_cnt                   <= '0;
            r_bank                  <= w_row_next[0];
            r_row_base              <= 15'(w_row_next * FB_W);
            r_valid[w_row_next[0]]  <= 1'b0;
          end
        end
        FETCH: r_cnt <= r_cnt + 1'b1;
        DRAIN: begin
          r_cnt          <= '0;
          r_valid[r_bank] <= 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Read address runs one pixel ahead so the registered read lines up with pix_x.
  assign w_rd_bank  = ((w_py / SCALE) % 2) != 32'd0;
  assign w_rd_ok    = r_valid[w_rd_bank] && (w_nx < WIDTH) && (w_py < HEIGHT);
  assign w_lb_raddr = w_rd_ok ? CW'(w_nx / SCALE) : '0;

  vga_fb_arbiter_line_buffer #(
    .DEPTH (FB_W),
    .AW    (CW)
  ) u_line_buffer (
    .clk       (clk_50),
    .i_wr_en   (r_lbw_en),
    .i_wr_bank (r_bank),
    .i_wr_addr (r_lbw_col),
    .i_wr_data (fb_rdata),
    .i_rd_bank (w_rd_bank),
    .i_rd_addr (w_lb_raddr),
    .o_rd_data (w_lb_rdata)
  );

  assign col = r_blank ? color_t'(0) : w_lb_rdata;

  // Writer only gets the port in IDLE cycles that are not about to start a fetch.
  assign wr_ready = (r_state == IDLE) && !w_trig && !rst;
  assign w_xfer   = wr_valid && wr_ready;
  assign w_wr_in  = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
  assign fb_wr_en = w_xfer && w_wr_in;
  assign fb_rd_en = (r_state == FETCH);

  always_comb begin
    fb_addr  = '0;
    fb_wdata = '0;
    if (fb_rd_en) begin
      fb_addr = r_row_base + 15'(r_cnt);
    end else if (fb_wr_en) begin
      fb_addr  = 15'(32'(wr_y) * FB_W + 32'(wr_x));
      fb_wdata = wr_color;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_vga_fb_arbiter
// Brief    : Randomised bench for vga_fb_arbiter against a behavioural model.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
  import vga_fb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pix_x, pix_y;
  color_t      col;
  logic [14:0] fb_addr;
  logic        fb_rd_en, fb_wr_en;
  color_t      fb_wdata, fb_rdata;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x, wr_y;
  color_t      wr_color;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk_50   (clk),
    .rst      (rst),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .col      (col),
    .fb_addr  (fb_addr),
    .fb_rd_en (fb_rd_en),
    .fb_wr_en (fb_wr_en),
    .fb_wdata (fb_wdata),
    .fb_rdata (fb_rdata),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_color (wr_color)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic color_t pat(input int a);
    return color_t'(a % 4096);
  endfunction

  // Framebuffer memory model: read data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (fb_rd_en) fb_rdata <= pat(int'(fb_addr));
    else          fb_rdata <= color_t'($urandom);
  end

  // Behavioural model: fk = 0 idle, 1..200 reading column fk-1, 201 drain.
  int     fk;
  int     frow;
  int     fbank;
  bit     mvalid [2];
  color_t mlb [2][200];
  color_t col_pend;

  always @(negedge clk) begin
    int px, py, ny, rb;
    bit trig, idle, exp_rd, exp_rdy, exp_wr;
    if (rst) begin
      chk("rst_rd_en",    32'(fb_rd_en), 32'd0);
      chk("rst_wr_en",    32'(fb_wr_en), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_fb_addr",  32'(fb_addr),  32'd0);
      chk("rst_col",      32'(col),      32'd0);
      fk = 0;
      mvalid[0] = 1'b0;
      mvalid[1] = 1'b0;
      col_pend = '0;
    end else begin
      px = int'(pix_x);
      py = int'(pix_y);
      ny = py + 1;
      trig    = (px == 800) && (((ny % 4 == 0) && (ny < 600)) || (py == 665));
      idle    = (fk == 0);
      exp_rd  = (fk >= 1) && (fk <= 200);
      exp_rdy = idle && !trig;
      exp_wr  = wr_valid && exp_rdy && (int'(wr_x) < 200) && (int'(wr_y) < 150);
      chk("rd_en",    32'(fb_rd_en), 32'(exp_rd));
      chk("wr_ready", 32'(wr_ready), 32'(exp_rdy));
      chk("wr_en",    32'(fb_wr_en), 32'(exp_wr));
      if (exp_rd) chk("rd_addr", 32'(fb_addr), 32'(frow * 200 + fk - 1));
      if (exp_wr) begin
        chk("wr_addr", 32'(fb_addr), 32'(int'(wr_y) * 200 + int'(wr_x)));
        chk("wr_data", 32'(fb_wdata), 32'(wr_color));
      end
      chk("col", 32'(col), 32'(col_pend));
      rb = (py / 4) % 2;
      col_pend = (mvalid[rb] && (px + 1 < 800) && (py < 600)) ? mlb[rb][(px + 1) / 4] : '0;
      if (fk == 0) begin
        if (trig) begin
          frow  = (py == 665) ? 0 : ny / 4;
          fbank = frow % 2;
          mvalid[fbank] = 1'b0;
          fk = 1;
        end
      end else if (fk <= 200) begin
        fk++;
      end else begin
        for (int c = 0; c < 200; c++) mlb[fbank][c] = pat(frow * 200 + c);
        mvalid[fbank] = 1'b1;
        fk = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_wr();
    wr_valid = 1'($urandom_range(0, 1));
    wr_x     = 8'($urandom_range(0, 220));
    wr_y     = 8'($urandom_range(0, 160));
    wr_color = color_t'($urandom);
  endtask

  // mode: 0 plain, 1 frame-end burst, 2 writer held through fetch, 3 reset mid-fetch,
  //       4 stray trigger during fetch, 5 line-0 pixel values, 6 dark line, 7 edge writes
  task automatic run_line(input int y, input int x0, input int mode);
    int n_rd, first_rd, last_rd, wr_idx, rdy_before, nz;
    int exp039 [9];
    bit hold;
    exp039 = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    n_rd = 0; first_rd = -1; last_rd = -1; wr_idx = -1; rdy_before = 0; nz = 0;
    hold = (mode == 2);
    for (int i = 0; i < 40; i++) begin
      tick();
      pix_y = 16'(y);
      pix_x = 16'(x0 + i);
      rand_wr();
      if (mode == 7 && i == 5) begin
        wr_valid = 1'b1; wr_x = 8'd199; wr_y = 8'd149; wr_color = 12'h123;
      end
      if (mode == 7 && i == 6) begin
        wr_valid = 1'b1; wr_x = 8'd200; wr_y = 8'd10;
      end
      #2;
      if (mode == 5 && i < 9) chk("line0_col", 32'(col), 32'(exp039[i]));
      if (mode == 6 && col != '0) nz++;
      if (mode == 7 && i == 5) begin
        chk("edge_wr_en", 32'(fb_wr_en), 32'd1);
        chk("edge_addr",  32'(fb_addr),  32'd29999);
      end
      if (mode == 7 && i == 6) begin
        chk("oob_ready", 32'(wr_ready), 32'd1);
        chk("oob_wr_en", 32'(fb_wr_en), 32'd0);
      end
    end
    if (mode == 6) chk("dark_line_nonzero", 32'(nz), 32'd0);
    tick();
    pix_x = 16'd800;
    rand_wr();
    if (hold) begin
      wr_valid = 1'b1; wr_x = 8'd5; wr_y = 8'd5; wr_color = 12'hABC;
    end
    for (int i = 0; i < 215; i++) begin
      tick();
      pix_x = 16'(801 + i);
      rand_wr();
      if (hold) begin
        wr_valid = 1'b1; wr_x = 8'd5; wr_y = 8'd5; wr_color = 12'hABC;
      end
      if (mode == 4 && i == 50) pix_x = 16'd800;
      if (mode == 3 && i == 103) rst = 1'b0;
      #2;
      if (mode == 1 && fb_rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = int'(fb_addr);
        last_rd = int'(fb_addr);
      end
      if (hold) begin
        if (fb_wr_en) begin
          wr_idx = i;
          chk("held_wr_addr", 32'(fb_addr), 32'd1005);
          hold = 1'b0;
        end else if (wr_ready) begin
          rdy_before++;
        end
      end
      if (mode == 3 && i == 100) begin
        chk("pre_rst_addr", 32'(fb_addr), 32'd500);
        rst = 1'b1;
        #1;
        chk("async_rd_en", 32'(fb_rd_en), 32'd0);
        chk("async_addr",  32'(fb_addr),  32'd0);
        chk("async_ready", 32'(wr_ready), 32'd0);
        chk("async_col",   32'(col),      32'd0);
      end
    end
    if (mode == 1) begin
      chk("burst_len",   32'(n_rd),     32'd200);
      chk("burst_first", 32'(first_rd), 32'd0);
      chk("burst_last",  32'(last_rd),  32'd199);
    end
    if (mode == 2) begin
      chk("held_wr_cycle",    32'(wr_idx),     32'd201);
      chk("held_ready_early", 32'(rdy_before), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_x = '0; pix_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    repeat (3) tick();
    rst = 1'b0;
    run_line(665, 700, 1);
    run_line(0, 0, 5);
    run_line(1, int'($urandom_range(0, 770)), 0);
    run_line(2, int'($urandom_range(0, 700)), 7);
    run_line(3, int'($urandom_range(0, 770)), 2);
    for (int y = 4; y < 7; y++) run_line(y, int'($urandom_range(0, 770)), 0);
    run_line(7, int'($urandom_range(0, 770)), 3);
    run_line(8, 0, 6);
    for (int y = 9; y < 20; y++) run_line(y, int'($urandom_range(0, 770)), 0);
    for (int k = 0; k < 12; k++)
      run_line(int'($urandom_range(0, 665)), int'($urandom_range(0, 770)), 4);
    run_line(599, int'($urandom_range(0, 770)), 0);
    run_line(663, int'($urandom_range(0, 770)), 0);
    run_line(665, int'($urandom_range(0, 770)), 4);
    for (int y = 0; y < 6; y++) run_line(y, int'($urandom_range(0, 770)), 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
